// File: rtl/canny_pkg.sv
// Shared definitions for the edge pipeline: frame geometry defaults, NMS sequencer
// state encoding and the per-result tag layout carried alongside the window stage.
package canny_pkg;

    localparam int CANNY_IMG_W = 1024;
    localparam int CANNY_IMG_H = 768;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int TAG_W   = 5;
    localparam int TAG_V   = 4;
    localparam int TAG_SOF = 3;
    localparam int TAG_EOL = 2;
    localparam int TAG_EOF = 1;
    localparam int TAG_BRD = 0;

    // Field order must match the TAG_* bit indices above.
    typedef struct packed {
        logic v;
        logic sof;
        logic eol;
        logic eof;
        logic border;
    } nms_tag_t;

    function automatic nms_tag_t make_tag(input logic sof, input logic eol,
                                          input logic eof, input logic border);
        nms_tag_t t;
        t.v      = 1'b1;
        t.sof    = sof;
        t.eol    = eol;
        t.eof    = eof;
        t.border = border;
        return t;
    endfunction

endpackage

// File: rtl/nms_tag_pipe.sv
// LAT-deep enabled shift register that carries result tags in lock-step with the
// NMS window stage; synchronous clear drops all in-flight tags.
module nms_tag_pipe import canny_pkg::*; #(
    parameter int LAT = 3,
    parameter int TW  = TAG_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic [TW-1:0] tag_in,
    output logic [TW-1:0] tag_out
);

    logic [LAT-1:0][TW-1:0] pipe_q;
    logic [LAT-1:0][TW-1:0] pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        if (clr) begin
            pipe_d = '0;
        end else if (en) begin
            pipe_d[0] = tag_in;
            for (int i = 1; i < LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[LAT-1];

endmodule

// File: rtl/nms_frame_seq.sv
// Frame sequencer for the 3x3 NMS stage: input handshake, stage enable, flush row and
// drain beats at frame end, and valid/sof/eol/eof/border tagging of each result.
//
//   state | meaning
//   IDLE  | waiting for start
//   FILL  | input row 0, window filling, no results tagged
//   RUN   | input rows 1..IMG_H-1, tag centre (row-1, col)
//   FLUSH | one zero row, tag centre (IMG_H-1, col)
//   DRAIN | LAT zero beats push the last tags out
//   DONE  | single-cycle completion pulse
module nms_frame_seq import canny_pkg::*; #(
    parameter int IMG_W = CANNY_IMG_W,
    parameter int IMG_H = CANNY_IMG_H,
    parameter int LAT   = 3,
    parameter int CW    = 11,
    parameter int RW    = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic s_valid,
    output logic s_ready,
    input  logic m_ready,
    output logic stage_en,
    output logic zero_sel,
    output logic m_valid,
    output logic m_sof,
    output logic m_eol,
    output logic m_eof,
    output logic m_border,
    output logic busy,
    output logic done
);

    localparam int LW = (LAT > 1) ? $clog2(LAT + 1) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [LW-1:0] DRN_START = LW'(LAT - 1);

    logic [2:0]    st_q, st_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [LW-1:0] drn_q, drn_d;

    logic             in_phase;
    logic             zero_phase;
    logic             col_last;
    logic             start_acc;
    nms_tag_t         tag_in;
    logic [TAG_W-1:0] tag_tail;

    assign in_phase   = (st_q == ST_FILL) || (st_q == ST_RUN);
    assign zero_phase = (st_q == ST_FLUSH) || (st_q == ST_DRAIN);
    assign col_last   = (col_q == COL_LAST);
    assign start_acc  = start && (st_q == ST_IDLE) && !abort;

    // Abort suppresses the beat in its own cycle so no pixel is consumed or result emitted.
    assign stage_en = !abort && m_ready && ((in_phase && s_valid) || zero_phase);
    assign s_ready  = !abort && m_ready && in_phase;
    assign zero_sel = zero_phase;
    assign busy     = (st_q != ST_IDLE);
    assign done     = (st_q == ST_DONE);

    always_comb begin
        tag_in = '0;
        if (st_q == ST_RUN) begin
            tag_in = make_tag((row_q == RW'(1)) && (col_q == '0),
                              col_last,
                              1'b0,
                              (row_q == RW'(1)) || (col_q == '0) || col_last);
        end else if (st_q == ST_FLUSH) begin
            tag_in = make_tag(1'b0, col_last, col_last, 1'b1);
        end
    end

    always_comb begin
        st_d  = st_q;
        col_d = col_q;
        row_d = row_q;
        drn_d = drn_q;
        if (abort) begin
            st_d  = ST_IDLE;
            col_d = '0;
            row_d = '0;
            drn_d = '0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (start) begin
                        st_d  = ST_FILL;
                        col_d = '0;
                        row_d = '0;
                        drn_d = '0;
                    end
                end
                ST_FILL, ST_RUN, ST_FLUSH: begin
                    if (stage_en) begin
                        if (col_last) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                            if (st_q == ST_FILL) begin
                                st_d = ST_RUN;
                            end else if (st_q == ST_RUN) begin
                                if (row_q == ROW_LAST) begin
                                    st_d = ST_FLUSH;
                                end
                            end else begin
                                st_d  = ST_DRAIN;
                                row_d = '0;
                                drn_d = DRN_START;
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (stage_en) begin
                        if (drn_q == '0) begin
                            st_d = ST_DONE;
                        end else begin
                            drn_d = drn_q - LW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    st_d = ST_IDLE;
                end
                default: begin
                    st_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_IDLE;
            col_q <= '0;
            row_q <= '0;
            drn_q <= '0;
        end else begin
            st_q  <= st_d;
            col_q <= col_d;
            row_q <= row_d;
            drn_q <= drn_d;
        end
    end

    // A fresh frame also clears the pipe so nothing from an earlier frame can leak out.
    nms_tag_pipe #(
        .LAT (LAT),
        .TW  (TAG_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (stage_en),
        .clr     (abort || start_acc),
        .tag_in  (tag_in),
        .tag_out (tag_tail)
    );

    assign m_valid  = stage_en && tag_tail[TAG_V];
    assign m_sof    = m_valid && tag_tail[TAG_SOF];
    assign m_eol    = m_valid && tag_tail[TAG_EOL];
    assign m_eof    = m_valid && tag_tail[TAG_EOF];
    assign m_border = m_valid && tag_tail[TAG_BRD];

endmodule

// File: tb/tb_nms_frame_seq.sv
// Directed bench for nms_frame_seq on an 8x4 frame with LAT=3.
module tb_nms_frame_seq;

    localparam int W = 8;
    localparam int H = 4;
    localparam int L = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic s_valid = 1'b0;
    logic m_ready = 1'b0;
    logic s_ready, stage_en, zero_sel, m_valid, m_sof, m_eol, m_eof, m_border, busy, done;

    always #5 clk = ~clk;

    nms_frame_seq #(
        .IMG_W (W),
        .IMG_H (H),
        .LAT   (L),
        .CW    (3),
        .RW    (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_ready  (m_ready),
        .stage_en (stage_en),
        .zero_sel (zero_sel),
        .m_valid  (m_valid),
        .m_sof    (m_sof),
        .m_eol    (m_eol),
        .m_eof    (m_eof),
        .m_border (m_border),
        .busy     (busy),
        .done     (done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit mon_on = 1'b0;
    int res_k, en_in, en_zero, done_cnt, brd_cnt, viol, zs_viol, cyc, last_en_cyc, done_cyc;
    int mr, mc;

    task automatic clear_mon();
        res_k = 0; en_in = 0; en_zero = 0; done_cnt = 0; brd_cnt = 0;
        viol = 0; zs_viol = 0; cyc = 0; last_en_cyc = -10; done_cyc = -10;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            cyc++;
            if (stage_en && !m_ready) viol++;
            if (m_valid && !stage_en) viol++;
            if (!m_valid && (m_sof || m_eol || m_eof || m_border)) viol++;
            if (s_ready && zero_sel) zs_viol++;
            if (stage_en) begin
                last_en_cyc = cyc;
                if (zero_sel) en_zero++;
                else en_in++;
            end
            if (m_valid) begin
                mr = res_k / W;
                mc = res_k % W;
                check("sof", m_sof, res_k == 0);
                check("eol", m_eol, mc == W - 1);
                check("eof", m_eof, res_k == W * H - 1);
                check("border", m_border, (mr == 0) || (mr == H - 1) || (mc == 0) || (mc == W - 1));
                if (m_border) brd_cnt++;
                res_k++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // rdy_mode 1: m_ready toggles 1010..; sv_mode 1: ~30% s_valid gaps;
    // poke: start pulsed during RUN and in the DONE cycle.
    task automatic run_frame(input string name, input int rdy_mode, input int sv_mode, input bit poke);
        bit got_done;
        clear_mon();
        mon_on = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            m_ready = (rdy_mode == 1) ? (c % 2 == 0) : 1'b1;
            s_valid = (sv_mode == 1) ? ($urandom_range(0, 9) >= 3) : 1'b1;
            start = poke && ((en_in == 12) || done);
            @(posedge clk); #1;
            if (done_cnt > 0) got_done = 1'b1;
        end
        start = 1'b0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        check({name, "_done_seen"}, got_done, 1);
        check({name, "_idle_after_done"}, busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_still_idle"}, busy, 0);
        mon_on = 1'b0;
        check({name, "_results"}, res_k, W * H);
        check({name, "_in_beats"}, en_in, W * H);
        check({name, "_zero_beats"}, en_zero, W + L);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_done_timing"}, done_cyc, last_en_cyc + 1);
        check({name, "_border_cnt"}, brd_cnt, 20);
        check({name, "_stall_viol"}, viol, 0);
        check({name, "_zero_sel_in_fill"}, zs_viol, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        s_valid = 1'b1;
        m_ready = 1'b1;
        #12;
        check("reset_outputs",
              {s_ready, stage_en, zero_sel, m_valid, m_sof, m_eol, m_eof, m_border, busy, done}, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {busy, stage_en, s_ready, zero_sel}, 0);

        run_frame("basic", 0, 0, 1'b0);
        run_frame("rdy_toggle", 1, 0, 1'b0);
        run_frame("sv_gaps", 0, 1, 1'b0);
        run_frame("both_stall", 1, 1, 1'b0);
        run_frame("start_poke", 0, 0, 1'b1);

        // Abort at input row 2, col 5 (beat 21).
        clear_mon();
        mon_on = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && en_in < 21; c++) begin
            @(posedge clk); #1;
        end
        check("abort_reach", en_in, 21);
        check("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", {busy, s_ready, stage_en, zero_sel}, 0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_stay_idle", busy, 0);
        mon_on = 1'b0;
        run_frame("post_abort", 0, 0, 1'b0);

        // Reset dropped mid-FLUSH.
        clear_mon();
        mon_on = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && en_zero < 3; c++) begin
            @(posedge clk); #1;
        end
        check("flush_reach", en_zero, 3);
        check("flush_zero_sel", zero_sel, 1);
        mon_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midflush_reset_outputs",
              {s_ready, stage_en, zero_sel, m_valid, m_sof, m_eol, m_eof, m_border, busy, done}, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        clear_mon();
        mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", busy, 0);
        check("post_reset_no_done", done_cnt, 0);
        mon_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
